// File: rtl/velocity_arbiter_if.sv
// Velocity write bus between physics producers and the velocity arbiter.
// The master drives the request side; the slave (arbiter) drives the issued update.
interface velocity_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int WIDTH   = 11
);
  logic [NUM_SRC-1:0]         inWriteEnable;
  logic [NUM_SRC*WIDTH-1:0]   inVelocityX;
  logic [NUM_SRC*WIDTH-1:0]   inVelocityY;
  logic signed [WIDTH-1:0]    outVelocityX;
  logic signed [WIDTH-1:0]    outVelocityY;
  logic                       WriteEnable;
  logic [$clog2(NUM_SRC)-1:0] outSource;
  logic [NUM_SRC-1:0]         pendingMask;
  logic [7:0]                 dropCount;

  modport master (
    output inWriteEnable, inVelocityX, inVelocityY,
    input  outVelocityX, outVelocityY, WriteEnable, outSource, pendingMask, dropCount
  );

  modport slave (
    input  inWriteEnable, inVelocityX, inVelocityY,
    output outVelocityX, outVelocityY, WriteEnable, outSource, pendingMask, dropCount
  );
endinterface

// File: rtl/velocity_arbiter.sv
// Merges per-source velocity write requests into one registered, clamped write port.
// Losers are buffered one deep; overwriting a buffered value is counted as a drop.
module velocity_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int WIDTH   = 11,
  parameter int VMAX    = 511,
  parameter int RR_MODE = 0
) (
  input logic               clk,
  input logic               reset,
  velocity_arbiter_if.slave bus
);
  localparam int SW = $clog2(NUM_SRC);
  localparam logic signed [WIDTH-1:0] VPOS = WIDTH'(VMAX);
  localparam logic signed [WIDTH-1:0] VNEG = -VPOS;

  logic [NUM_SRC-1:0]      pending;
  logic signed [WIDTH-1:0] buf_x [NUM_SRC];
  logic signed [WIDTH-1:0] buf_y [NUM_SRC];
  logic [SW-1:0]           rr_ptr;
  logic [7:0]              drop_count;
  logic                    we_q;
  logic [SW-1:0]           src_q;
  logic signed [WIDTH-1:0] x_q;
  logic signed [WIDTH-1:0] y_q;

  logic [NUM_SRC-1:0]      active;
  logic [NUM_SRC-1:0]      drop;
  logic [NUM_SRC-1:0]      grant_oh;
  logic signed [WIDTH-1:0] eff_x [NUM_SRC];
  logic signed [WIDTH-1:0] eff_y [NUM_SRC];
  logic                    grant_any;
  logic [SW-1:0]           grant_idx;
  logic [SW-1:0]           next_ptr;

  // Both operands are WIDTH-bit signed, so the most negative code simply clamps to VNEG.
  function automatic logic signed [WIDTH-1:0] clamp(input logic signed [WIDTH-1:0] v);
    if (v > VPOS) return VPOS;
    if (v < VNEG) return VNEG;
    return v;
  endfunction

  assign active = bus.inWriteEnable | pending;
  assign drop   = bus.inWriteEnable & pending;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      eff_x[i] = bus.inWriteEnable[i] ? bus.inVelocityX[i*WIDTH +: WIDTH] : buf_x[i];
      eff_y[i] = bus.inWriteEnable[i] ? bus.inVelocityY[i*WIDTH +: WIDTH] : buf_y[i];
    end
  end

  // Descending scan: the last hit written is the first candidate in search order.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    if (RR_MODE == 0) begin
      for (int i = NUM_SRC-1; i >= 0; i--) begin
        if (active[i]) begin
          grant_any = 1'b1;
          grant_idx = SW'(i);
        end
      end
    end else begin
      for (int k = NUM_SRC-1; k >= 0; k--) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_SRC) idx = idx - NUM_SRC;
        if (active[idx]) begin
          grant_any = 1'b1;
          grant_idx = SW'(idx);
        end
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (grant_any) grant_oh[grant_idx] = 1'b1;
  end

  assign next_ptr = (grant_idx == SW'(NUM_SRC-1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending    <= '0;
      rr_ptr     <= '0;
      drop_count <= '0;
      we_q       <= 1'b0;
      src_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        buf_x[i] <= '0;
        buf_y[i] <= '0;
      end
    end else begin
      if ((|drop) && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;

      for (int i = 0; i < NUM_SRC; i++) begin
        if (grant_oh[i]) begin
          pending[i] <= 1'b0;
        end else if (active[i]) begin
          pending[i] <= 1'b1;
          buf_x[i]   <= eff_x[i];
          buf_y[i]   <= eff_y[i];
        end
      end

      if (grant_any) begin
        we_q   <= 1'b1;
        src_q  <= grant_idx;
        x_q    <= clamp(eff_x[grant_idx]);
        y_q    <= clamp(eff_y[grant_idx]);
        rr_ptr <= next_ptr;
      end else begin
        we_q  <= 1'b0;
        src_q <= '0;
        x_q   <= '0;
        y_q   <= '0;
      end
    end
  end

  assign bus.WriteEnable  = we_q;
  assign bus.outSource    = src_q;
  assign bus.outVelocityX = x_q;
  assign bus.outVelocityY = y_q;
  assign bus.pendingMask  = pending;
  assign bus.dropCount    = drop_count;
endmodule

// File: tb/tb_velocity_arbiter.sv
// Bench for velocity_arbiter: fixed-priority and round-robin instances driven with the
// same stimulus and compared cycle by cycle against a rule-level reference model.
module tb_velocity_arbiter;
  localparam int N  = 4;
  localparam int W  = 11;
  localparam int VM = 511;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  velocity_arbiter_if #(.NUM_SRC(N), .WIDTH(W)) bus0 ();
  velocity_arbiter_if #(.NUM_SRC(N), .WIDTH(W)) bus1 ();

  velocity_arbiter #(.NUM_SRC(N), .WIDTH(W), .VMAX(VM), .RR_MODE(0)) dut0 (
    .clk(clk), .reset(rst), .bus(bus0));
  velocity_arbiter #(.NUM_SRC(N), .WIDTH(W), .VMAX(VM), .RR_MODE(1)) dut1 (
    .clk(clk), .reset(rst), .bus(bus1));

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] s_we;
  int           s_x [N];
  int           s_y [N];

  logic [N-1:0] m_pend [2];
  int           m_bx   [2][N];
  int           m_by   [2][N];
  int           m_rr   [2];
  int           m_drop [2];
  int e_we [2];
  int e_src[2];
  int e_x  [2];
  int e_y  [2];

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clampv(input int v);
    if (v > VM)  return VM;
    if (v < -VM) return -VM;
    return v;
  endfunction

  function automatic int rand_v();
    case ($urandom_range(0, 15))
      0: return -1024;
      1: return 1023;
      2: return 512;
      3: return -512;
      default: return int'($urandom_range(0, 2047)) - 1024;
    endcase
  endfunction

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      m_pend[m] = '0;
      m_rr[m]   = 0;
      m_drop[m] = 0;
      for (int i = 0; i < N; i++) begin
        m_bx[m][i] = 0;
        m_by[m][i] = 0;
      end
    end
  endtask

  task automatic model_step(input int m);
    logic [N-1:0] act;
    int ex[N];
    int ey[N];
    int g;
    int idx;
    act = s_we | m_pend[m];
    for (int i = 0; i < N; i++) begin
      ex[i] = s_we[i] ? s_x[i] : m_bx[m][i];
      ey[i] = s_we[i] ? s_y[i] : m_by[m][i];
    end
    if ((s_we & m_pend[m]) != '0) m_drop[m] = (m_drop[m] >= 255) ? 255 : m_drop[m] + 1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m == 0) ? k : (m_rr[m] + k) % N;
      if (g < 0 && act[idx]) g = idx;
    end
    if (g < 0) begin
      e_we[m] = 0; e_src[m] = 0; e_x[m] = 0; e_y[m] = 0;
    end else begin
      e_we[m]  = 1;
      e_src[m] = g;
      e_x[m]   = clampv(ex[g]);
      e_y[m]   = clampv(ey[g]);
      for (int i = 0; i < N; i++) begin
        if (i == g) m_pend[m][i] = 1'b0;
        else if (act[i]) begin
          m_pend[m][i] = 1'b1;
          m_bx[m][i]   = ex[i];
          m_by[m][i]   = ey[i];
        end
      end
      if (m == 1) m_rr[m] = (g + 1) % N;
    end
  endtask

  task automatic sample(input int m, output int we, output int src, output int x,
                        output int y, output int pm, output int dc);
    if (m == 0) begin
      we = int'(bus0.WriteEnable); src = int'(bus0.outSource);
      x = int'(bus0.outVelocityX); y = int'(bus0.outVelocityY);
      pm = int'(bus0.pendingMask); dc = int'(bus0.dropCount);
    end else begin
      we = int'(bus1.WriteEnable); src = int'(bus1.outSource);
      x = int'(bus1.outVelocityX); y = int'(bus1.outVelocityY);
      pm = int'(bus1.pendingMask); dc = int'(bus1.dropCount);
    end
  endtask

  task automatic drive();
    bus0.inWriteEnable = s_we;
    bus1.inWriteEnable = s_we;
    for (int i = 0; i < N; i++) begin
      bus0.inVelocityX[i*W +: W] = s_x[i][W-1:0];
      bus0.inVelocityY[i*W +: W] = s_y[i][W-1:0];
      bus1.inVelocityX[i*W +: W] = s_x[i][W-1:0];
      bus1.inVelocityY[i*W +: W] = s_y[i][W-1:0];
    end
  endtask

  task automatic cycle(input string ph);
    int we, src, x, y, pm, dc;
    drive();
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      model_step(m);
      sample(m, we, src, x, y, pm, dc);
      check_val($sformatf("%s.m%0d.we", ph, m), we, e_we[m]);
      check_val($sformatf("%s.m%0d.src", ph, m), src, e_src[m]);
      check_val($sformatf("%s.m%0d.x", ph, m), x, e_x[m]);
      check_val($sformatf("%s.m%0d.y", ph, m), y, e_y[m]);
      check_val($sformatf("%s.m%0d.pend", ph, m), pm, int'(m_pend[m]));
      check_val($sformatf("%s.m%0d.drops", ph, m), dc, m_drop[m]);
    end
  endtask

  // Reset is raised mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    int we, src, x, y, pm, dc;
    rst  = 1'b1;
    s_we = '0;
    drive();
    model_clear();
    #2;
    for (int m = 0; m < 2; m++) begin
      sample(m, we, src, x, y, pm, dc);
      check_val($sformatf("%s.m%0d.we", tag, m), we, 0);
      check_val($sformatf("%s.m%0d.src", tag, m), src, 0);
      check_val($sformatf("%s.m%0d.x", tag, m), x, 0);
      check_val($sformatf("%s.m%0d.y", tag, m), y, 0);
      check_val($sformatf("%s.m%0d.pend", tag, m), pm, 0);
      check_val($sformatf("%s.m%0d.drops", tag, m), dc, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < N; i++) begin
      s_x[i] = rand_v();
      s_y[i] = rand_v();
    end
  endtask

  initial begin
    s_we = '0;
    for (int i = 0; i < N; i++) begin
      s_x[i] = 0;
      s_y[i] = 0;
    end
    do_reset("reset");

    // single uncontested request
    s_we = 4'b0100; s_x[2] = 100; s_y[2] = -50;
    cycle("single");
    check_val("single.we", int'(bus0.WriteEnable), 1);
    check_val("single.src", int'(bus0.outSource), 2);
    check_val("single.x", int'(bus0.outVelocityX), 100);
    check_val("single.y", int'(bus0.outVelocityY), -50);
    s_we = '0;
    cycle("single_idle");
    check_val("single_idle.we", int'(bus0.WriteEnable), 0);
    check_val("single_idle.x", int'(bus0.outVelocityX), 0);

    // three simultaneous requests, fixed priority
    randomize_data();
    s_we = 4'b1011;
    cycle("three_a");
    check_val("three_a.src", int'(bus0.outSource), 0);
    check_val("three_a.pend", int'(bus0.pendingMask), 4'b1010);
    s_we = '0;
    cycle("three_b");
    check_val("three_b.src", int'(bus0.outSource), 1);
    check_val("three_b.pend", int'(bus0.pendingMask), 4'b1000);
    cycle("three_c");
    check_val("three_c.src", int'(bus0.outSource), 3);
    check_val("three_c.pend", int'(bus0.pendingMask), 0);
    cycle("three_idle");

    // clamp boundaries
    s_we = 4'b0001; s_x[0] = 700; s_y[0] = -1024;
    cycle("clamp_over");
    check_val("clamp_over.x", int'(bus0.outVelocityX), 511);
    check_val("clamp_over.y", int'(bus0.outVelocityY), -511);
    s_x[0] = 511; s_y[0] = -511;
    cycle("clamp_edge");
    check_val("clamp_edge.x", int'(bus0.outVelocityX), 511);
    check_val("clamp_edge.y", int'(bus0.outVelocityY), -511);
    s_we = '0;
    cycle("clamp_idle");

    // round-robin under full load
    do_reset("rr_reset");
    for (int k = 0; k < 8; k++) begin
      randomize_data();
      s_we = 4'b1111;
      cycle("rr_load");
      check_val($sformatf("rr_load.src%0d", k), int'(bus1.outSource), k % N);
    end
    s_we = '0;
    for (int k = 0; k < 4; k++) cycle("rr_drain");

    // overwrite of a buffered request
    do_reset("ow_reset");
    s_we = 4'b1001; s_x[0] = 1; s_y[0] = 1; s_x[3] = 3; s_y[3] = 3;
    cycle("ow_a");
    s_x[3] = 7; s_y[3] = -7;
    cycle("ow_b");
    check_val("ow_b.drops", int'(bus0.dropCount), 1);
    check_val("ow_b.pend", int'(bus0.pendingMask), 4'b1000);
    s_we = '0;
    cycle("ow_c");
    check_val("ow_c.src", int'(bus0.outSource), 3);
    check_val("ow_c.x", int'(bus0.outVelocityX), 7);
    cycle("ow_idle");
    check_val("ow_idle.we", int'(bus0.WriteEnable), 0);

    // drop counter saturation
    do_reset("sat_reset");
    for (int k = 0; k < 300; k++) begin
      randomize_data();
      s_we = 4'b1111;
      cycle("sat");
    end
    check_val("sat.drops", int'(bus0.dropCount), 255);
    s_we = '0;
    for (int k = 0; k < 4; k++) cycle("sat_drain");

    // reset in the middle of a burst
    randomize_data();
    s_we = 4'b1111;
    cycle("mid_burst");
    check_val("mid_burst.pend", int'(bus0.pendingMask), 4'b1110);
    do_reset("mid_reset");
    for (int k = 0; k < 3; k++) cycle("post_reset");

    // randomized traffic
    for (int k = 0; k < 2000; k++) begin
      randomize_data();
      for (int i = 0; i < N; i++) s_we[i] = ($urandom_range(0, 9) < 4);
      cycle("rand");
    end
    s_we = '0;
    for (int k = 0; k < 5; k++) cycle("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/velocity_arbiter.md
# velocity_arbiter

Parametrised, registered velocity-update arbiter for the ball physics path. It merges velocity write requests from NUM_SRC producers, such as cue-line launch, ball-ball hit and cushion hit, into the single velocity write port of a ball's velocity register. Requests that lose arbitration are buffered one deep per source instead of being discarded, and each issued value is clamped to ±VMAX. Losses caused by buffer overwrite are counted.

## Interface
- NUM_SRC, 4: number of request sources, 2..8
- WIDTH, 11: signed velocity component width
- VMAX, 511: clamp magnitude, 0 < VMAX ≤ 2^(WIDTH-1)-1
- RR_MODE, 0: 0 = fixed priority (index 0 highest); 1 = round-robin
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- inWriteEnable  in  NUM_SRC  per-source request strobe, one cycle per request
- inVelocityX  in  NUM_SRC*WIDTH  packed signed X, source i at [i*WIDTH +: WIDTH]
- inVelocityY  in  NUM_SRC*WIDTH  packed signed Y, same packing
- outVelocityX  out  WIDTH  registered, clamped signed X
- outVelocityY  out  WIDTH  registered, clamped signed Y
- WriteEnable  out  1  registered, one-cycle strobe per issued update
- outSource  out  $clog2(NUM_SRC)  index of the issued source
- pendingMask  out  NUM_SRC  buffered, not-yet-issued requests
- dropCount  out  8  saturating count of cycles with ≥1 overwrite loss

## Operation
- Per source i, a request is active when inWriteEnable[i] | pending[i].
- Effective data: incoming X/Y when inWriteEnable[i] is high, otherwise the buffered X/Y. New data always supersedes buffered data.
- Drop: inWriteEnable[i] & pending[i] in the same cycle. The old buffered value is lost.
- dropCount increments by 1 in any cycle with at least one drop and saturates at 255.
- Grant, RR_MODE=0: the lowest active index wins.
- Grant, RR_MODE=1: the search starts at pointer rrPtr and ascends with wrap. The first active source wins. After a grant to g, rrPtr ← (g+1) mod NUM_SRC. rrPtr is unchanged when there is no grant.
- On a grant at an edge:
  - WriteEnable ← 1, outSource ← g, outVelocityX/Y ← clamp of the effective data of g.
  - pending[g] ← 0.
- Every active non-granted source i: pending[i] ← 1 and its buffer ← effective data.
- No active source: WriteEnable ← 0, outVelocityX/Y ← 0, outSource ← 0.
- Clamp is per component: v > VMAX → VMAX; v < −VMAX → −VMAX; otherwise unchanged. Compare in signed WIDTH arithmetic with no widening overflow. The value −2^(WIDTH-1) clamps to −VMAX.
- pendingMask reflects the pending registers directly.

## Timing
- Reset, asynchronous: all outputs 0, pending 0, buffers 0, rrPtr 0, dropCount 0. A request in flight during reset is lost.
- First rising edge with reset low resumes normal operation.
- Latency: an uncontested request presented before edge e gives WriteEnable=1 with its data after edge e, i.e. 1 cycle.
- Throughput: one issued update per cycle.
- Burst of k simultaneous requests: k consecutive WriteEnable cycles, provided no new requests arrive in between.
- A source with a pending request and a fresh request in the same cycle is issued once, with the fresh data, and the drop is counted. This holds whether or not it wins.
- Fixed-priority mode can starve high indices under sustained load. This is accepted; RR_MODE=1 bounds the wait to NUM_SRC−1 cycles.

## Test plan
- Reset mid-burst: three requests pending, assert reset → all outputs, pendingMask and dropCount 0 immediately, before the next edge. After release, no stale WriteEnable occurs.
- Single request, source 2, X=100, Y=−50, RR_MODE=0 → next cycle WriteEnable=1, outSource=2, X=100, Y=−50. The cycle after, WriteEnable=0 and X/Y=0.
- Simultaneous sources 0, 1 and 3, RR_MODE=0 → issues in order 0, 1, 3 on three consecutive cycles. pendingMask goes 1010b then 1000b then 0000b.
- Round-robin, RR_MODE=1, all four sources requesting every cycle for 8 cycles → outSource sequence 0,1,2,3,0,1,2,3. dropCount increments on every cycle after the first. Pending sources are overwritten each cycle.
- Clamp, WIDTH=11, VMAX=511: X=700 and Y=−1024 → X=511, Y=−511. X=511 and Y=−511 pass through unchanged.
- Overwrite: source 3 is buffered behind source 0, then source 3 requests again with X=7 while source 0 is still busy → source 3 is later issued once with X=7. dropCount goes 0→1. dropCount saturates at 255 after 300 forced drops.
